// File: rtl/ks_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - borrow_in, one register per prefix level.
// Optional signed-overflow output is enabled by defining KS_SUB_OVERFLOW_EN.
module ks_subtractor_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  borrow_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] diff_o,
  output logic                  borrow_o
`ifdef KS_SUB_OVERFLOW_EN
  ,
  output logic                  ovf_o
`endif
);

  localparam int W      = DATA_WIDTH;
  localparam int STAGES = $clog2(DATA_WIDTH);

  // Handshake: an operand set is accepted on a rising edge when valid_i & ready_o;
  // a result is consumed on a rising edge when valid_o & ready_i. The whole pipe
  // advances together when the output slot is empty or being drained.
  logic w_adv;

  logic [W-1:0] r_a   [0:STAGES];
  logic [W-1:0] r_nb  [0:STAGES];
  logic [W-1:0] r_g   [0:STAGES];
  logic [W-1:0] r_p   [0:STAGES];
  logic         r_cin [0:STAGES];
  logic [STAGES:0] r_vld;

`ifdef KS_SUB_OVERFLOW_EN
  logic [STAGES:0] r_amsb;
  logic [STAGES:0] r_bmsb;
`endif

  logic [W-1:0] w_g_nxt [1:STAGES];
  logic [W-1:0] w_p_nxt [1:STAGES];
  logic [W:0]   w_carry;
  logic [W-1:0] w_diff;

  assign valid_o = r_vld[STAGES];
  assign w_adv   = ~valid_o | ready_i;
  assign ready_o = w_adv;

  // Prefix level i combines each bit with the one 2^(i-1) positions below it.
  always_comb begin
    for (int i = 1; i <= STAGES; i++) begin
      w_g_nxt[i] = r_g[i-1];
      w_p_nxt[i] = r_p[i-1];
      for (int j = (1 << (i - 1)); j < W; j++) begin
        w_g_nxt[i][j] = r_g[i-1][j] | (r_p[i-1][j] & r_g[i-1][j-(1 << (i - 1))]);
        w_p_nxt[i][j] = r_p[i-1][j] & r_p[i-1][j-(1 << (i - 1))];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= '0;
      for (int i = 0; i <= STAGES; i++) begin
        r_a[i]   <= '0;
        r_nb[i]  <= '0;
        r_g[i]   <= '0;
        r_p[i]   <= '0;
        r_cin[i] <= 1'b0;
      end
`ifdef KS_SUB_OVERFLOW_EN
      r_amsb <= '0;
      r_bmsb <= '0;
`endif
    end else if (w_adv) begin
      r_vld[0] <= valid_i;
      r_a[0]   <= a_i;
      r_nb[0]  <= ~b_i;
      r_g[0]   <= a_i & ~b_i;
      r_p[0]   <= a_i | ~b_i;
      r_cin[0] <= ~borrow_i;
      for (int i = 1; i <= STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_a[i]   <= r_a[i-1];
        r_nb[i]  <= r_nb[i-1];
        r_g[i]   <= w_g_nxt[i];
        r_p[i]   <= w_p_nxt[i];
        r_cin[i] <= r_cin[i-1];
      end
`ifdef KS_SUB_OVERFLOW_EN
      r_amsb <= {r_amsb[STAGES-1:0], a_i[W-1]};
      r_bmsb <= {r_bmsb[STAGES-1:0], b_i[W-1]};
`endif
    end
  end

  // Group generate/propagate cover bits [k:0], so the carry into k+1 needs only cin.
  assign w_carry = {r_g[STAGES] | (r_p[STAGES] & {W{r_cin[STAGES]}}), r_cin[STAGES]};
  assign w_diff  = r_a[STAGES] ^ r_nb[STAGES] ^ w_carry[W-1:0];

  // Outputs are forced low without a valid result so they read 0 after reset.
  assign diff_o   = valid_o ? w_diff : '0;
  assign borrow_o = valid_o & ~w_carry[W];

`ifdef KS_SUB_OVERFLOW_EN
  assign ovf_o = valid_o & (r_amsb[STAGES] != r_bmsb[STAGES])
                         & (w_diff[W-1] != r_amsb[STAGES]);
`endif

endmodule
